// File: rtl/if_npc_gen_if.sv
// Fetch-side bundle between the IF next-PC generator and the rest of the core.
// slave = next-PC generator, master = hazard/ID/EX side driving redirects.
interface if_npc_gen_if #(
    parameter int CNT_W = 32
);
    logic             en;
    logic             pd;
    logic [31:0]      paddr;
    logic             JalD;
    logic             pdD;
    logic [31:0]      JalNPC;
    logic             JalrE;
    logic [31:0]      AluOutE;
    logic [2:0]       BranchTypeE;
    logic             BranchE;
    logic             pdE;
    logic [31:0]      PCE;
    logic [31:0]      BrNPC;
    logic [31:0]      PCF;
    logic             FlushD;
    logic             FlushE;
    logic [CNT_W-1:0] BrCnt;
    logic [CNT_W-1:0] MispCnt;

    modport master (
        output en, pd, paddr, JalD, pdD, JalNPC,
        output JalrE, AluOutE, BranchTypeE,
        output BranchE, pdE, PCE, BrNPC,
        input  PCF, FlushD, FlushE, BrCnt, MispCnt
    );

    modport slave (
        input  en, pd, paddr, JalD, pdD, JalNPC,
        input  JalrE, AluOutE, BranchTypeE,
        input  BranchE, pdE, PCE, BrNPC,
        output PCF, FlushD, FlushE, BrCnt, MispCnt
    );
endinterface

// File: rtl/if_npc_gen.sv
// IF next-PC select and fetch-PC register with ID/EX flush generation.
// Define PERF_CNT_EN to build the branch / mispredict counters.
module if_npc_gen #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input logic         clk,
    input logic         rst_n,
    if_npc_gen_if.slave bus
);
    localparam logic [31:0] ALIGN = 32'hFFFF_FFFC;

    logic [31:0] pcf;
    logic [31:0] npc;
    logic        ld;
    logic        flush_d;
    logic        flush_e;

    logic br_e;
    logic misp_e;
    logic c_br;
    logic c_fall;
    logic c_jalr;
    logic c_jal;
    logic c_pd;

    assign br_e   = bus.BranchTypeE != 3'b000;
    assign misp_e = br_e & (bus.BranchE ^ bus.pdE);

    // One-hot select so the decoder below stays strictly unique.
    assign c_br   = misp_e & bus.BranchE;
    assign c_fall = misp_e & ~bus.BranchE;
    assign c_jalr = ~misp_e & bus.JalrE;
    assign c_jal  = ~misp_e & ~bus.JalrE
                  & bus.JalD & ~bus.pdD;
    assign c_pd   = ~misp_e & ~bus.JalrE
                  & ~(bus.JalD & ~bus.pdD) & bus.pd;

    always_comb begin
        npc     = pcf + 32'd4;
        ld      = bus.en;
        flush_d = 1'b0;
        flush_e = 1'b0;
        unique case (1'b1)
            c_br: begin
                npc     = bus.BrNPC & ALIGN;
                ld      = 1'b1;
                flush_d = 1'b1;
                flush_e = 1'b1;
            end
            c_fall: begin
                npc     = (bus.PCE + 32'd4) & ALIGN;
                ld      = 1'b1;
                flush_d = 1'b1;
                flush_e = 1'b1;
            end
            c_jalr: begin
                npc     = bus.AluOutE & ALIGN;
                ld      = 1'b1;
                flush_d = 1'b1;
                flush_e = 1'b1;
            end
            c_jal: begin
                npc     = bus.JalNPC & ALIGN;
                flush_d = 1'b1;
            end
            c_pd: begin
                npc = bus.paddr & ALIGN;
            end
            default: begin
                npc = (pcf + 32'd4) & ALIGN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcf <= RESET_PC;
        end else if (ld) begin
            pcf <= npc;
        end
    end

    assign bus.PCF    = pcf;
    assign bus.FlushD = flush_d;
    assign bus.FlushE = flush_e;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] misp_cnt;

    // Counts every EX cycle regardless of fetch stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt   <= '0;
            misp_cnt <= '0;
        end else begin
            if (br_e) begin
                br_cnt <= br_cnt + CNT_W'(1);
            end
            if (misp_e) begin
                misp_cnt <= misp_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.BrCnt   = br_cnt;
    assign bus.MispCnt = misp_cnt;
`else
    assign bus.BrCnt   = '0;
    assign bus.MispCnt = '0;
`endif
endmodule
